demux_pkt_sched: RTL and testbench
==================================

DEMUX_PKT_SCHED -- requirements
Module: demux_pkt_sched

Interface
REQ-001 The module SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-004 The module SHALL have port en, input, 1 bit, which enables the start of new packets.
REQ-005 The module SHALL have port ch_en, input, 2 bits, per-output-channel eligibility mask.
REQ-006 The module SHALL have ports in_data (input, DW bits), in_valid (input, 1 bit), in_last (input, 1 bit) and in_ready (output, 1 bit), forming the upstream stream.
REQ-007 The module SHALL have ports y0_data (output, DW bits), y0_valid (output, 1 bit), y0_last (output, 1 bit) and y0_ready (input, 1 bit), forming channel 0.
REQ-008 The module SHALL have ports y1_data, y1_valid, y1_last and y1_ready, with the same directions and widths as channel 0, forming channel 1.
REQ-009 The module SHALL have port s, output, 1 bit, the channel locked for the current packet.
REQ-010 The module SHALL have port busy, output, 1 bit, high while a packet is in progress.

Function
REQ-011 A beat SHALL be accepted upstream when in_valid && in_ready; a beat SHALL be delivered on channel k when yk_valid && yk_ready.
REQ-012 The FSM SHALL have two states, IDLE and XFER; in IDLE, in_ready=0 and busy=0.
REQ-013 In IDLE, when en && in_valid && |ch_en, the FSM SHALL latch s and go to XFER next cycle; otherwise it SHALL stay in IDLE.
REQ-014 Channel choice SHALL be round-robin: s = ptr if ch_en[ptr], else s = ~ptr; ptr is 0 after reset.
REQ-015 In XFER, in_ready SHALL equal !ys_valid || ys_ready (single-entry output register for channel s).
REQ-016 An accepted beat SHALL appear on ys_data/ys_last with ys_valid=1 exactly one cycle later (latency 1); full throughput of one beat per cycle SHALL be sustained when ys_ready=1.
REQ-017 A held output beat SHALL keep data, last and valid stable until delivered.
REQ-018 The unselected channel SHALL receive no new beats; an earlier beat still held on it SHALL drain normally.
REQ-019 On acceptance of a beat with in_last=1, the module SHALL set ptr to ~s and return to IDLE; the next packet start costs exactly one IDLE cycle.
REQ-020 Changes of ch_en or deassertion of en during XFER SHALL have no effect until the packet ends; the current packet always completes.
REQ-021 With ch_en=2'b00 or en=0, the module SHALL stay in IDLE with in_ready=0, and in_valid SHALL be ignored.
REQ-022 A single-beat packet (in_last on the first beat) SHALL be legal, and ptr SHALL toggle on it.

Reset
REQ-023 When rst is high, the FSM SHALL go to IDLE and set ptr=0, s=0, busy=0, in_ready=0, y0_valid=y1_valid=0, y0_last=y1_last=0 and y0_data=y1_data=0.
REQ-024 Reset mid-packet SHALL discard the packet in progress and all held beats, with no partial beat delivered afterwards.

Configuration
REQ-025 Macro DEMUX_PKT_SCHED_CNT_EN, when defined, SHALL add output ports pkt_cnt0 and pkt_cnt1 (16 bits each).
REQ-026 pkt_cntk SHALL count delivered beats with yk_last=1, wrap 16'hFFFF->0, and reset to 0.
REQ-027 Without DEMUX_PKT_SCHED_CNT_EN, the ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-028 Shared package demux_pkt_pkg SHALL hold: FSM state enum (IDLE, XFER), CNT_W=16, 1-bit channel index typedef.
REQ-029 Sub-module demux_out_reg (one-entry valid/ready output register, parameter DW) SHALL be instantiated once per channel.

Verification
REQ-030 The bench SHALL cover: ch_en=11, 3 packets of 4 beats, yk_ready=1 -> packets on ch0, ch1, ch0; each beat 1 cycle after accept; one IDLE cycle between packets.
REQ-031 The bench SHALL cover: ch_en=10 after reset -> first packet on ch1 (ptr=0 skipped), then ptr=0 -> next packet again on ch1.
REQ-032 The bench SHALL cover: y0_ready=0 for 5 cycles mid-packet -> one beat held stable on y0, in_ready=0 in those cycles, no beat lost or duplicated.
REQ-033 The bench SHALL cover: ch_en changed 11->01 during a ch1 packet -> packet completes on ch1; next packet on ch0.
REQ-034 The bench SHALL cover: rst pulsed at beat 2 of a 4-beat packet -> next cycle all valid=0, busy=0, s=0; new packet goes to ch0.
REQ-035 The bench SHALL cover, with DEMUX_PKT_SCHED_CNT_EN: pkt_cnt0 preloaded by traffic to 16'hFFFF, one more ch0 packet -> pkt_cnt0=0, pkt_cnt1 unchanged.

Source files
------------

// File: rtl/demux_pkt_pkg.sv
// Shared types and constants for the packet demultiplexer/scheduler.
package demux_pkt_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  typedef logic ch_idx_t;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register; free_c says a beat can be loaded this cycle.
module demux_out_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last,
  output logic          free_c
);

  assign free_c = !valid || ready;

  // Data and last only change on a load, so a held beat stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (free_c) begin
      valid <= load;
      if (load) begin
        data <= load_data;
        last <= load_last;
      end
    end
  end

endmodule

// File: rtl/demux_pkt_sched.sv
// Packet demultiplexer: locks each packet to one of two channels, round-robin over ch_en.
// Optional per-channel packet counters with DEMUX_PKT_SCHED_CNT_EN.
module demux_pkt_sched
  import demux_pkt_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    ch_en,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] y0_data,
  output logic          y0_valid,
  output logic          y0_last,
  input  logic          y0_ready,
  output logic [DW-1:0] y1_data,
  output logic          y1_valid,
  output logic          y1_last,
  input  logic          y1_ready,
  output logic          s,
  output logic          busy
`ifdef DEMUX_PKT_SCHED_CNT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
`endif
);

  state_e  state, state_nxt;
  ch_idx_t ptr, ptr_nxt;
  ch_idx_t s_nxt;
  logic    load0, load1;
  logic    free0, free1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      s     <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      s     <= s_nxt;
    end
  end

  // Channel is chosen once per packet; ch_en/en are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    s_nxt     = s;
    in_ready  = 1'b0;
    load0     = 1'b0;
    load1     = 1'b0;
    case (state)
      IDLE: begin
        if (en && in_valid && (ch_en != 2'b00)) begin
          s_nxt     = ch_en[ptr] ? ptr : ~ptr;
          state_nxt = XFER;
        end
      end
      XFER: begin
        in_ready = s ? free1 : free0;
        if (in_valid && in_ready) begin
          load0 = !s;
          load1 = s;
          if (in_last) begin
            ptr_nxt   = ~s;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == XFER);

  demux_out_reg #(.DW(DW)) u_out0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (y0_ready),
    .valid     (y0_valid),
    .data      (y0_data),
    .last      (y0_last),
    .free_c    (free0)
  );

  demux_out_reg #(.DW(DW)) u_out1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (y1_ready),
    .valid     (y1_valid),
    .data      (y1_data),
    .last      (y1_last),
    .free_c    (free1)
  );

`ifdef DEMUX_PKT_SCHED_CNT_EN
  // Counts packets delivered per channel, wrapping at the counter width.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (y0_valid && y0_ready && y0_last) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (y1_valid && y1_ready && y1_last) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_pkt_sched.sv
// Self-checking bench for demux_pkt_sched: directed scenarios plus random traffic against a beat-level model.
module tb_demux_pkt_sched;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [1:0]    ch_en;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic [DW-1:0] y0_data, y1_data;
  logic          y0_valid, y0_last, y0_ready;
  logic          y1_valid, y1_last, y1_ready;
  logic          s, busy;
`ifdef DEMUX_PKT_SCHED_CNT_EN
  logic [15:0]   pkt_cnt0, pkt_cnt1;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: packet in progress, its channel, rr pointer, and the beat held per channel.
  bit            m_busy = 1'b0;
  bit            m_s    = 1'b0;
  bit            m_ptr  = 1'b0;
  bit            m_acc  = 1'b0;
  bit            mv [2];
  logic [DW-1:0] md [2];
  bit            ml [2];
  logic [15:0]   m_cnt [2];

  always #5 clk = ~clk;

  demux_pkt_sched #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ch_en    (ch_en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .y0_data  (y0_data),
    .y0_valid (y0_valid),
    .y0_last  (y0_last),
    .y0_ready (y0_ready),
    .y1_data  (y1_data),
    .y1_valid (y1_valid),
    .y1_last  (y1_last),
    .y1_ready (y1_ready),
    .s        (s),
    .busy     (busy)
`ifdef DEMUX_PKT_SCHED_CNT_EN
    ,
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_s = 1'b0; m_ptr = 1'b0; m_acc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; md[k] = '0; ml[k] = 1'b0; m_cnt[k] = '0;
    end
  endtask

  // Compare at the negedge, advance the model across the next posedge, return at posedge+1.
  task automatic tick();
    bit yr [2];
    bit exp_ir, acc, start;
    @(negedge clk);
    yr[0] = y0_ready;
    yr[1] = y1_ready;
    exp_ir = m_busy && (!mv[m_s] || yr[m_s]);
    chk("busy", busy, m_busy);
    chk("s", s, m_s);
    chk("in_ready", in_ready, exp_ir);
    chk("y0_valid", y0_valid, mv[0]);
    chk("y1_valid", y1_valid, mv[1]);
    if (mv[0]) begin
      chk("y0_data", y0_data, md[0]);
      chk("y0_last", y0_last, ml[0]);
    end
    if (mv[1]) begin
      chk("y1_data", y1_data, md[1]);
      chk("y1_last", y1_last, ml[1]);
    end
`ifdef DEMUX_PKT_SCHED_CNT_EN
    chk("pkt_cnt0", pkt_cnt0, m_cnt[0]);
    chk("pkt_cnt1", pkt_cnt1, m_cnt[1]);
`endif
    if (rst) begin
      model_reset();
    end else begin
      acc   = in_valid && exp_ir;
      start = !m_busy && en && in_valid && (ch_en != 2'b00);
      for (int k = 0; k < 2; k++) begin
        if (mv[k] && yr[k]) begin
          mv[k] = 1'b0;
          if (ml[k]) m_cnt[k] = m_cnt[k] + 16'd1;
        end
      end
      if (acc) begin
        mv[m_s] = 1'b1; md[m_s] = in_data; ml[m_s] = in_last;
        if (in_last) begin
          m_busy = 1'b0;
          m_ptr  = !m_s;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_s    = ch_en[m_ptr] ? m_ptr : !m_ptr;
      end
      m_acc = acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int ch, input logic v);
    if (ch == 0) y0_ready = v; else y1_ready = v;
  endtask

  // Present one beat and wait (bounded) until it is accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input bit rnd);
    in_data = d; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rnd) begin
        y0_ready = 1'($urandom);
        y1_ready = 1'($urandom);
      end
      tick();
      if (m_acc) break;
    end
    chk("accept_timeout", m_acc, 1);
  endtask

  // exp_ch < 0: channel not checked; stall_at/chg_at < 0: feature unused.
  task automatic send_pkt(input int n, input int exp_ch, input int stall_at, input int stall_len,
                          input int chg_at, input logic [1:0] chg_val, input bit rnd);
    bit done;
    for (int b = 0; b < n; b++) begin
      done = 1'b0;
      if (b == stall_at) begin
        in_data = DW'($urandom); in_last = (b == n - 1); in_valid = 1'b1;
        set_ready(exp_ch, 1'b0);
        for (int i = 0; i < stall_len; i++) begin
          tick();
          chk("stall_held_valid", (exp_ch == 0) ? y0_valid : y1_valid, 1);
          if (m_acc) done = 1'b1;
        end
        set_ready(exp_ch, 1'b1);
        if (!done) send_beat(in_data, in_last, rnd);
      end else begin
        send_beat(DW'($urandom), (b == n - 1), rnd);
      end
      if (b == 0 && exp_ch >= 0) chk("pkt_ch", s, exp_ch);
      if (b == chg_at) ch_en = chg_val;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [15:0] cnt1_save;
    rst = 1'b1; en = 1'b0; ch_en = 2'b00;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    y0_ready = 1'b1; y1_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_y0_data", y0_data, 0);
    chk("rst_y1_data", y1_data, 0);
    chk("rst_y0_last", y0_last, 0);
    chk("rst_y1_last", y1_last, 0);
    tick();
    rst = 1'b0;

    // Idle with nothing eligible or disabled: input is ignored.
    en = 1'b1; ch_en = 2'b00; in_valid = 1'b1; in_data = 8'hA5;
    idle_ticks(3);
    en = 1'b0; ch_en = 2'b11;
    idle_ticks(3);
    in_valid = 1'b0;

    // Round-robin over both channels, back-to-back 4-beat packets.
    en = 1'b1; ch_en = 2'b11;
    send_pkt(4, 0, -1, 0, -1, 2'b00, 1'b0);
    send_pkt(4, 1, -1, 0, -1, 2'b00, 1'b0);
    send_pkt(4, 0, -1, 0, -1, 2'b00, 1'b0);
    idle_ticks(2);

    // Only ch1 eligible after reset: ptr=0 is skipped twice.
    rst = 1'b1; tick(); rst = 1'b0;
    ch_en = 2'b10;
    send_pkt(4, 1, -1, 0, -1, 2'b00, 1'b0);
    send_pkt(3, 1, -1, 0, -1, 2'b00, 1'b0);
    idle_ticks(2);

    // Backpressure on ch0 for 5 cycles mid-packet.
    rst = 1'b1; tick(); rst = 1'b0;
    ch_en = 2'b11;
    send_pkt(4, 0, 2, 5, -1, 2'b00, 1'b0);

    // ch_en drops ch1 during a ch1 packet; packet still finishes on ch1.
    send_pkt(4, 1, -1, 0, 1, 2'b01, 1'b0);
    send_pkt(2, 0, -1, 0, -1, 2'b00, 1'b0);

    // Single-beat packets toggle the pointer.
    ch_en = 2'b11;
    send_pkt(1, 1, -1, 0, -1, 2'b00, 1'b0);
    send_pkt(1, 0, -1, 0, -1, 2'b00, 1'b0);
    idle_ticks(2);

    // Reset at beat 2 of a 4-beat ch1 packet drops everything.
    send_beat(DW'($urandom), 1'b0, 1'b0);
    chk("pre_rst_ch", s, 1);
    send_beat(DW'($urandom), 1'b0, 1'b0);
    y1_ready = 1'b0;
    in_data = DW'($urandom); rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; y1_ready = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_s", s, 0);
    chk("rst_y0_valid", y0_valid, 0);
    chk("rst_y1_valid", y1_valid, 0);
    idle_ticks(3);
    send_pkt(4, 0, -1, 0, -1, 2'b00, 1'b0);

    // Random traffic: lengths, eligibility, mid-packet mask changes, ready toggling.
    for (int p = 0; p < 40; p++) begin
      ch_en = 2'($urandom_range(3, 1));
      if ($urandom_range(3, 0) == 0) begin
        en = 1'b0; in_valid = 1'b1;
        idle_ticks(2);
        en = 1'b1;
      end
      send_pkt(int'($urandom_range(5, 1)), -1, -1, 0, int'($urandom_range(4, 0)),
               2'($urandom), 1'b1);
    end
    y0_ready = 1'b1; y1_ready = 1'b1;
    idle_ticks(3);

`ifdef DEMUX_PKT_SCHED_CNT_EN
    // Drive ch0 packet count to the wrap point, then one more packet.
    ch_en = 2'b01;
    while (m_cnt[0] != 16'hFFFF) begin
      send_pkt(1, 0, -1, 0, -1, 2'b00, 1'b0);
      idle_ticks(1);
    end
    idle_ticks(2);
    chk("cnt0_preload", pkt_cnt0, 16'hFFFF);
    cnt1_save = pkt_cnt1;
    send_pkt(1, 0, -1, 0, -1, 2'b00, 1'b0);
    idle_ticks(3);
    chk("cnt0_wrap", pkt_cnt0, 0);
    chk("cnt1_hold", pkt_cnt1, cnt1_save);
`else
    cnt1_save = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
